// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter with a small transmit FIFO.
//
// Bytes pushed with data_valid are queued in a FIFO_DEPTH-entry FIFO. The
// transmitter pops one entry per frame. At the moment of the pop it snapshots
// the data and the line configuration (bit period, parity mode, stop bits).
// Because of this snapshot, configuration changes made while a frame is on the
// line only take effect from the next frame.
//
// Build option: define UART_TX_PARITY_EN to enable the parity bit. Without it
// the parity_mode input is ignored and every frame is sent without parity.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   FIFO_DEPTH  transmit FIFO entries (power of two, >= 2)
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   data_valid    push request; data sampled on the same edge
//   data          word to transmit
//   clks_per_bit  bit period in clk cycles (values below 2 act as 2)
//   parity_mode   00/11 none, 01 even, 10 odd
//   two_stop      1 = two stop bits
//   tx            serial output, idle high (registered)
//   busy          frame in progress or FIFO not empty
//   full          FIFO holds FIFO_DEPTH entries
//   done          one-cycle pulse during the last stop-bit cycle of a frame
//   overflow      one-cycle pulse after a push was dropped because FIFO was full
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_valid,
  input  logic [DATA_BITS-1:0] data,
  input  logic [15:0]          clks_per_bit,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 done,
  output logic                 overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [PW:0]   DEPTH    = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  state_t state_reg, state_next;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]          count_reg;
  logic                 empty, push, pop;

  // Per-frame snapshot and bit timing
  logic [DATA_BITS-1:0] frame_data_reg;
  logic [15:0]          cpb_last_reg;   // bit period minus one
  logic                 two_stop_reg;
  logic [15:0]          cnt_reg;
  logic [IW-1:0]        bit_idx_reg;
  logic                 stop_idx_reg;
  logic                 bit_last, stop_end;
  logic                 tx_next, done_next;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH);
  assign push  = data_valid && !full;
  assign busy  = (state_reg != IDLE) || !empty;

  assign bit_last = (cnt_reg == cpb_last_reg);
  // The final stop bit is the first one with one stop bit, else the second.
  assign stop_end = (state_reg == STOP) && bit_last && (stop_idx_reg || !two_stop_reg);

`ifdef UART_TX_PARITY_EN
  logic [1:0] parity_reg;
  logic       parity_on, parity_bit;
  assign parity_on  = (parity_reg == 2'b01) || (parity_reg == 2'b10);
  assign parity_bit = (parity_reg == 2'b10) ? ~(^frame_data_reg) : ^frame_data_reg;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  // FIFO write port (no reset: contents are only meaningful below count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
      // Judged on the pre-edge full flag, so a pop on the same edge does
      // not rescue the dropped push.
      overflow <= data_valid && full;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a pop always coincides with entry into START
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: if (bit_last) state_next = DATA;
      DATA: begin
        if (bit_last && (bit_idx_reg == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_next = parity_on ? PARITY : STOP;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_last) state_next = STOP;
`endif
      STOP: begin
        if (stop_end) begin
          if (!empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; tx and done are registered below
  always_comb begin
    tx_next   = 1'b1;
    done_next = 1'b0;
    case (state_reg)
      START:  tx_next = 1'b0;
      DATA:   tx_next = frame_data_reg[bit_idx_reg];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = parity_bit;
`endif
      STOP:   done_next = stop_end;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx   <= 1'b1;
      done <= 1'b0;
    end else begin
      tx   <= tx_next;
      done <= done_next;
    end
  end

  // Frame snapshot and bit/cycle counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data_reg <= '0;
      cpb_last_reg   <= 16'd1;
      two_stop_reg   <= 1'b0;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      stop_idx_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= 2'b00;
`endif
    end else if (pop) begin
      frame_data_reg <= mem[rd_ptr_reg];
      cpb_last_reg   <= (clks_per_bit < 16'd2) ? 16'd1 : (clks_per_bit - 16'd1);
      two_stop_reg   <= two_stop;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      stop_idx_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= parity_mode;
`endif
    end else if (state_reg != IDLE) begin
      if (bit_last) begin
        cnt_reg <= '0;
        if (state_reg == DATA) bit_idx_reg  <= bit_idx_reg + 1'b1;
        if (state_reg == STOP) stop_idx_reg <= ~stop_idx_reg;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg. A line-receiver process checks every frame
// cycle by cycle against scoreboard entries queued when bytes are pushed.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        data_valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [15:0] clks_per_bit = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  logic        tx, busy, full, done, overflow;

  uart_tx_cfg #(.DATA_BITS(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
    .clks_per_bit(clks_per_bit), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx(tx), .busy(busy), .full(full), .done(done), .overflow(overflow)
  );

  // Narrow-data instance
  logic        dv5 = 1'b0;
  logic [4:0]  data5 = 5'h00;
  logic [15:0] cpb5 = 16'd2;
  logic [1:0]  pm5 = 2'b00;
  logic        ts5 = 1'b0;
  logic        tx5, busy5, full5, done5, ovf5;

  uart_tx_cfg #(.DATA_BITS(5), .FIFO_DEPTH(2)) u_dut5 (
    .clk(clk), .reset(reset), .data_valid(dv5), .data(data5),
    .clks_per_bit(cpb5), .parity_mode(pm5), .two_stop(ts5),
    .tx(tx5), .busy(busy5), .full(full5), .done(done5), .overflow(ovf5)
  );

  typedef struct {
    logic [7:0] d;
    int         cpb;
    logic [1:0] pm;
    logic       ts;
  } frame_t;

  typedef struct {
    logic [7:0] d;
    int         cpb;
    logic [1:0] pm;
    logic       ts;
    int         exp_len;
  } vec_t;

  frame_t sb[$];
  int     gaps[$];
  int     lens[$];
  int     frames_rx = 0;
  int     done_cnt = 0;
  int     ovf_cnt = 0;
  int     compared = 0;
  int     mismatched = 0;
  time    t_end = 0;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1)     done_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  // Line receiver: validates every cycle of every frame against the model.
  initial begin : monitor
    frame_t e;
    logic   lv[$];
    int     cpb_eff, bad, dbad, ncyc, guard;
    bit     abort;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      if (sb.size() == 0) begin
        chk("unexpected_start", 1, 0);
        guard = 0;
        while (tx === 1'b0 && guard < 2000) begin @(negedge clk); guard++; end
        continue;
      end
      e = sb.pop_front();
      gaps.push_back(int'(($time - t_end) / 10) - 1);
      lv.delete();
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(e.d[i]);
`ifdef UART_TX_PARITY_EN
      if (e.pm == 2'b01) lv.push_back(^e.d);
      if (e.pm == 2'b10) lv.push_back(~(^e.d));
`endif
      lv.push_back(1'b1);
      if (e.ts) lv.push_back(1'b1);
      cpb_eff = (e.cpb < 2) ? 2 : e.cpb;
      abort = 0; dbad = 0; ncyc = 0;
      for (int k = 0; k < lv.size() && !abort; k++) begin
        bad = 0;
        for (int c = 0; c < cpb_eff; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b0) begin abort = 1; break; end
          ncyc++;
          if (tx !== lv[k]) bad++;
          if (done !== ((k == lv.size() - 1) && (c == cpb_eff - 1))) dbad++;
        end
        if (!abort) chk($sformatf("frame%0d_bit%0d_badcycles", frames_rx, k), bad, 0);
      end
      if (abort) begin
        sb.delete();   // reset discards queued bytes
      end else begin
        chk($sformatf("frame%0d_done_badcycles", frames_rx), dbad, 0);
        lens.push_back(ncyc);
        t_end = $time;
        frames_rx++;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_rx < target && n < budget) begin @(negedge clk); n++; end
    if (frames_rx < target) chk("wait_frames_timeout", frames_rx, target);
  endtask

  // Push one byte from idle and check start latency, frame length, idle after.
  task automatic send_frame(input logic [7:0] d, input int cpb, input logic [1:0] pm,
                            input logic ts, input int exp_len, input string nm);
    int f0;
    f0 = frames_rx;
    lens.delete();
    clks_per_bit = 16'(cpb); parity_mode = pm; two_stop = ts;
    data = d; data_valid = 1'b1;
    sb.push_back('{d, cpb, pm, ts});
    @(negedge clk);                       // edge N sampled the push
    data_valid = 1'b0;
    chk({nm, "_busy_after_push"}, busy, 1);
    chk({nm, "_tx_idle_N"}, tx, 1);
    @(negedge clk);
    chk({nm, "_tx_idle_N1"}, tx, 1);
    @(negedge clk);
    chk({nm, "_tx_start_N2"}, tx, 0);
    wait_frames(f0 + 1, exp_len + 20);
    chk({nm, "_frame_len"}, qget(lens, 0), exp_len);
    repeat (2) @(negedge clk);
    chk({nm, "_busy_idle"}, busy, 0);
    $display("frame %s data=%02h cpb=%0d pm=%0d ts=%0d len=%0d", nm, d, cpb, pm, ts, qget(lens, 0));
  endtask

  vec_t vecs[7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  f0, n, d0, bad, dbad, lvl;
    logic prev;
    logic [4:0] v5;
    logic [7:0] burst [6];

    vecs[0] = '{8'hA5, 4, 2'b00, 1'b0, 40};
    vecs[1] = '{8'h00, 3, 2'b00, 1'b0, 30};
    vecs[2] = '{8'hFF, 5, 2'b11, 1'b1, 55};
    vecs[3] = '{8'h5A, 0, 2'b00, 1'b0, 20};
    vecs[4] = '{8'h81, 1, 2'b00, 1'b1, 22};
    vecs[5] = '{8'h07, 4, 2'b01, 1'b1, (12 + PAR_BITS - 1) * 4};   // 48 with parity, 44 without
    vecs[6] = '{8'h07, 4, 2'b10, 1'b0, (11 + PAR_BITS - 1) * 4};   // 44 with parity, 40 without

    // Asynchronous reset: outputs settle before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx5", tx5, 1);
    chk("rst_busy5", busy5, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      send_frame(vecs[i].d, vecs[i].cpb, vecs[i].pm, vecs[i].ts, vecs[i].exp_len,
                 $sformatf("vec%0d", i));

    // Burst from idle: the first byte is popped on the edge after its push,
    // so the FIFO fills on the fifth push and the sixth is the dropped one.
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    f0 = frames_rx;
    gaps.delete();
    clks_per_bit = 16'd2; parity_mode = 2'b00; two_stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data = burst[i]; data_valid = 1'b1;
      if (i < 5) sb.push_back('{burst[i], 2, 2'b00, 1'b0});
      @(negedge clk);
      if (i == 4) chk("burst_full_set", full, 1);
      if (i == 5) chk("burst_overflow_pulse", overflow, 1);
    end
    data_valid = 1'b0;
    @(negedge clk);
    chk("burst_overflow_one_cycle", overflow, 0);
    n = 0; prev = full;
    while (done !== 1'b1 && n < 40) begin prev = full; @(negedge clk); n++; end
    chk("burst_first_done_seen", done, 1);
    chk("burst_full_before_pop", prev, 1);
    chk("burst_full_after_pop", full, 0);
    wait_frames(f0 + 5, 300);
    chk("burst_frames", gaps.size(), 5);
    for (int i = 1; i < 5; i++) chk($sformatf("burst_gap%0d", i), qget(gaps, i), 0);
    $display("burst frames=%0d overflow_pulses=%0d", frames_rx - f0, ovf_cnt);

    // Configuration change during a frame applies only to the next frame
    repeat (3) @(negedge clk);
    f0 = frames_rx;
    gaps.delete(); lens.delete();
    clks_per_bit = 16'd4; two_stop = 1'b0;
    data = 8'hC3; data_valid = 1'b1;
    sb.push_back('{8'hC3, 4, 2'b00, 1'b0});
    @(negedge clk);
    data_valid = 1'b0;
    repeat (6) @(negedge clk);
    clks_per_bit = 16'd8; two_stop = 1'b1;
    data = 8'h3C; data_valid = 1'b1;
    sb.push_back('{8'h3C, 8, 2'b00, 1'b1});
    @(negedge clk);
    data_valid = 1'b0;
    wait_frames(f0 + 2, 300);
    chk("cfgchg_len_a", qget(lens, 0), 40);
    chk("cfgchg_len_b", qget(lens, 1), 88);
    chk("cfgchg_gap", qget(gaps, 1), 0);
    $display("cfgchg lens=%0d,%0d", qget(lens, 0), qget(lens, 1));
    clks_per_bit = 16'd4; two_stop = 1'b0;

    // Reset in the middle of data bit 3
    repeat (3) @(negedge clk);
    data = 8'hF0; data_valid = 1'b1;
    sb.push_back('{8'hF0, 4, 2'b00, 1'b0});
    @(negedge clk);
    data_valid = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("midrst_frame_started", tx, 0);
    repeat (17) @(negedge clk);
    chk("midrst_tx_low_before", tx, 0);
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_full", full, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    reset = 1'b0;
    send_frame(8'h3C, 4, 2'b00, 1'b0, 40, "after_reset");

    // DATA_BITS=5: start + 5 data + 1 stop at 2 cycles/bit = 14 cycles
    for (int j = 0; j < 2; j++) begin
      v5 = (j == 0) ? 5'h1F : 5'h06;
      @(negedge clk);
      data5 = v5; dv5 = 1'b1;
      @(negedge clk);
      dv5 = 1'b0;
      @(negedge clk);
      chk($sformatf("dut5_%0h_idle_N1", v5), tx5, 1);
      bad = 0; dbad = 0;
      for (int t = 0; t < 14; t++) begin
        @(negedge clk);
        if (t / 2 == 0)      lvl = 0;
        else if (t / 2 <= 5) lvl = int'(v5[t / 2 - 1]);
        else                 lvl = 1;
        if (tx5 !== 1'(lvl)) bad++;
        if (done5 !== (t == 13)) dbad++;
      end
      chk($sformatf("dut5_%0h_bits_badcycles", v5), bad, 0);
      chk($sformatf("dut5_%0h_done_badcycles", v5), dbad, 0);
      repeat (2) @(negedge clk);
      chk($sformatf("dut5_%0h_busy_idle", v5), busy5, 0);
      $display("dut5 frame data=%02h", v5);
    end

    repeat (5) @(negedge clk);
    chk("done_pulses_vs_frames", done_cnt, frames_rx);
    chk("overflow_pulses_total", ovf_cnt, 1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
